song_note_sequencer: RTL and testbench



---
 rtl/song_note_sequencer.sv | 145 ++++++++++++++
 tb/tb_song_note_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/song_note_sequencer.sv
// Song table sequencer feeding the tone clock divider: steps through a fixed
// note table, timing each note in prescaled ticks with an optional silent gap.
module song_note_sequencer #(
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 1,
    parameter int LOOP      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] half_period,
    output logic        tone_en,
    output logic [3:0]  note_index,
    output logic        note_strobe,
    output logic        busy,
    output logic        done
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]    GAP_LEN   = 8'(GAP_TICKS);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    state_t         state_reg;
    logic [15:0]    half_period_reg;
    logic [7:0]     dur_reg;
    logic [TW-1:0]  tick_cnt_reg;
    logic [7:0]     dur_cnt_reg;
    logic [3:0]     note_index_reg;
    logic           tone_en_reg;
    logic           note_strobe_reg;
    logic           busy_reg;
    logic           done_reg;

    logic [15:0]    entry_hp;
    logic [7:0]     entry_dur;
    logic           tick_wrap;

    // dur = 0 marks the end of the song
    always_comb begin
        entry_hp  = 16'h0000;
        entry_dur = 8'd0;
        case (note_index_reg)
            4'd0: begin entry_hp = 16'h0BAA; entry_dur = 8'd3; end
            4'd1: begin entry_hp = 16'h0A6A; entry_dur = 8'd2; end
            4'd2: begin entry_hp = 16'h0000; entry_dur = 8'd1; end
            4'd3: begin entry_hp = 16'h08E4; entry_dur = 8'd2; end
            default: begin entry_hp = 16'h0000; entry_dur = 8'd0; end
        endcase
    end

    assign tick_wrap = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            state_reg       <= IDLE;
            half_period_reg <= 16'h0000;
            dur_reg         <= 8'd0;
            tick_cnt_reg    <= '0;
            dur_cnt_reg     <= 8'd0;
            note_index_reg  <= 4'd0;
            tone_en_reg     <= 1'b0;
            note_strobe_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            note_strobe_reg <= 1'b0;
            done_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    note_index_reg <= 4'd0;
                    if (start) begin
                        state_reg <= LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (entry_dur != 8'd0) begin
                        state_reg       <= PLAY;
                        half_period_reg <= entry_hp;
                        dur_reg         <= entry_dur;
                        tick_cnt_reg    <= '0;
                        dur_cnt_reg     <= 8'd0;
                        tone_en_reg     <= (entry_hp != 16'h0000);
                        note_strobe_reg <= 1'b1;
                    end else if ((LOOP != 0) && (note_index_reg != 4'd0)) begin
                        note_index_reg <= 4'd0;
                    end else begin
                        state_reg       <= DONE;
                        half_period_reg <= 16'h0000;
                        tone_en_reg     <= 1'b0;
                        busy_reg        <= 1'b0;
                        done_reg        <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!tick_wrap) begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                    end else begin
                        tick_cnt_reg <= '0;
                        if (dur_cnt_reg + 8'd1 == dur_reg) begin
                            dur_cnt_reg <= 8'd0;
                            tone_en_reg <= 1'b0;
                            if (GAP_TICKS > 0) begin
                                state_reg <= GAP;
                            end else begin
                                state_reg      <= LOAD;
                                note_index_reg <= note_index_reg + 4'd1;
                            end
                        end else begin
                            dur_cnt_reg <= dur_cnt_reg + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (!tick_wrap) begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                    end else begin
                        tick_cnt_reg <= '0;
                        if (dur_cnt_reg + 8'd1 == GAP_LEN) begin
                            dur_cnt_reg    <= 8'd0;
                            state_reg      <= LOAD;
                            note_index_reg <= note_index_reg + 4'd1;
                        end else begin
                            dur_cnt_reg <= dur_cnt_reg + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state_reg      <= IDLE;
                    note_index_reg <= 4'd0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign half_period = half_period_reg;
    assign tone_en     = tone_en_reg;
    assign note_index  = note_index_reg;
    assign note_strobe = note_strobe_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
endmodule

// File: tb/tb_song_note_sequencer.sv
// Random start/stop/reset against a per-cycle expected-output schedule built
// from the song table; one instance stops at the end, one loops with no gap.
module tb_song_note_sequencer;
    localparam int TICK   = 4;
    localparam int CYCLES = 3000;

    typedef struct packed {
        logic [15:0] hp;
        logic        tone;
        logic [3:0]  idx;
        logic        strobe;
        logic        busy;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start, stop;
    logic [15:0] hp_a, hp_b;
    logic tone_a, tone_b, strobe_a, strobe_b, busy_a, busy_b, done_a, done_b;
    logic [3:0] idx_a, idx_b;

    always #5 clk = ~clk;

    song_note_sequencer #(.TICK_DIV(TICK), .GAP_TICKS(1), .LOOP(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .half_period(hp_a), .tone_en(tone_a), .note_index(idx_a),
        .note_strobe(strobe_a), .busy(busy_a), .done(done_a)
    );

    song_note_sequencer #(.TICK_DIV(TICK), .GAP_TICKS(0), .LOOP(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .half_period(hp_b), .tone_en(tone_b), .note_index(idx_b),
        .note_strobe(strobe_b), .busy(busy_b), .done(done_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done_a = 0;
    int n_strobe_b = 0;

    logic [15:0] song_hp [4];
    int          song_dur[4];

    exp_t qa[$];
    exp_t qb[$];
    exp_t cur_a, cur_b, obs;
    bit   idle_a, idle_b;
    localparam exp_t IDLE_EXP = '{hp: 16'h0, tone: 1'b0, idx: 4'd0, strobe: 1'b0, busy: 1'b0, done: 1'b0};

    task automatic push(input int which, input exp_t e);
        if (which == 0) qa.push_back(e);
        else            qb.push_back(e);
    endtask

    // One pass over the table, starting right after a LOAD of entry 0.
    task automatic append_pass(input int which);
        int gap;
        gap = (which == 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < song_dur[i] * TICK; c++)
                push(which, '{song_hp[i], song_hp[i] != 16'h0, 4'(i), c == 0, 1'b1, 1'b0});
            for (int c = 0; c < gap * TICK; c++)
                push(which, '{song_hp[i], 1'b0, 4'(i), 1'b0, 1'b1, 1'b0});
            push(which, '{song_hp[i], 1'b0, 4'(i + 1), 1'b0, 1'b1, 1'b0});
        end
        if (which == 0) push(which, '{16'h0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1});
        else            push(which, '{song_hp[3], 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic check(input string tag, input exp_t o, input exp_t e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed hp=%h tone=%b idx=%0d strobe=%b busy=%b done=%b expected hp=%h tone=%b idx=%0d strobe=%b busy=%b done=%b",
                   tag, cyc, o.hp, o.tone, o.idx, o.strobe, o.busy, o.done,
                   e.hp, e.tone, e.idx, e.strobe, e.busy, e.done);
        end
    endtask

    initial begin
        song_hp[0] = 16'h0BAA; song_dur[0] = 3;
        song_hp[1] = 16'h0A6A; song_dur[1] = 2;
        song_hp[2] = 16'h0000; song_dur[2] = 1;
        song_hp[3] = 16'h08E4; song_dur[3] = 2;

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        cur_a = IDLE_EXP; cur_b = IDLE_EXP; idle_a = 1'b1; idle_b = 1'b1;
        @(posedge clk);
        @(posedge clk);

        for (cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            obs = '{hp_a, tone_a, idx_a, strobe_a, busy_a, done_a};
            check("seq_stop", obs, cur_a);
            obs = '{hp_b, tone_b, idx_b, strobe_b, busy_b, done_b};
            check("seq_loop", obs, cur_b);
            if (done_a) n_done_a++;
            if (strobe_b && idx_b == 4'd0) n_strobe_b++;

            // Clean first song, then random control with occasional reset.
            reset = (cyc == 1500) || (cyc == 2200) || (cyc == 20);
            if (cyc < 70) begin
                start = (cyc == 1) || (cyc == 6);
                stop  = (cyc == 62) && 1'b0;
            end else begin
                start = ($urandom_range(3) == 0);
                stop  = ($urandom_range(119) == 0) || (start && $urandom_range(9) == 0);
            end
            if (cyc == 20) reset = 1'b0;

            if (reset || stop) begin
                qa.delete(); qb.delete();
                cur_a = IDLE_EXP; cur_b = IDLE_EXP; idle_a = 1'b1; idle_b = 1'b1;
            end else begin
                if (idle_a && start) begin
                    qa.delete();
                    qa.push_back('{16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
                    append_pass(0);
                end
                if (qa.size() > 0) begin cur_a = qa.pop_front(); idle_a = 1'b0; end
                else begin cur_a = IDLE_EXP; idle_a = 1'b1; end

                if (idle_b && start) begin
                    qb.delete();
                    qb.push_back('{16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
                    append_pass(1);
                end
                if (qb.size() > 0) begin cur_b = qb.pop_front(); idle_b = 1'b0; end
                else begin cur_b = IDLE_EXP; idle_b = 1'b1; end
                if (!idle_b && qb.size() < 64) append_pass(1);
            end
        end

        @(negedge clk);
        n_assert++;
        assert (n_done_a > 0 && n_strobe_b > 1) else begin
            n_fail++;
            $error("FAIL activity observed done_pulses=%0d loop_strobes=%0d expected >0 and >1",
                   n_done_a, n_strobe_b);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
